// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_prescaler.sv
// Tick generator: counts enabled cycles 0..PRESCALE-1 and pulses tick on the wrap.
// Only instantiated when DOWN_COUNTER_PRESCALE_EN is defined.
module down_counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_count;

    // Combinational tick so the decrement lands on the same edge the count wraps.
    assign tick = enable && (r_count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= tick ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and optional auto-reload.
// Optional prescaler enabled by defining DOWN_COUNTER_PRESCALE_EN.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter_out,
    output logic             zero,
    output logic             busy,
    output logic             tc_pulse
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc_pulse;
    logic             w_step;

`ifdef DOWN_COUNTER_PRESCALE_EN
    logic w_presc_en;

    // The prescaler only advances on cycles that could otherwise decrement.
    assign w_presc_en = enable && (r_state == RUN) && !load;

    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (w_presc_en),
        .tick   (w_step)
    );
`else
    logic w_unused_prescale;

    assign w_unused_prescale = (PRESCALE == 0);
    assign w_step            = enable;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_tc_pulse <= 1'b0;
        end else begin
            r_tc_pulse <= 1'b0;
            if (load) begin
                r_count  <= load_value;
                r_reload <= load_value;
                r_state  <= (load_value != '0) ? RUN : IDLE;
            end else if ((r_state == RUN) && w_step) begin
                if (r_count == WIDTH'(1)) begin
                    // Terminal event: reload skips zero entirely so the period equals the reload value.
                    r_tc_pulse <= 1'b1;
                    if (auto_reload) begin
                        r_count <= r_reload;
                    end else begin
                        r_count <= '0;
                        r_state <= DONE;
                    end
                end else if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign counter_out = r_count;
    assign zero        = (r_count == '0);
    assign busy        = (r_state == RUN);
    assign tc_pulse    = r_tc_pulse;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4).
// Defining DOWN_COUNTER_PRESCALE_EN switches to the PRESCALE=4 sequence.
module tb_down_counter_timer;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] counter_out;
    logic             zero;
    logic             busy;
    logic             tc_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    down_counter_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .counter_out (counter_out),
        .zero        (zero),
        .busy        (busy),
        .tc_pulse    (tc_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Checks the four outputs at once against hand-computed values.
    task automatic check_all(input string tag, input int cnt, input logic tc, input logic bsy);
        check({tag, ".count"}, 32'(counter_out), 32'(cnt));
        check({tag, ".tc"},    32'(tc_pulse),    32'(tc));
        check({tag, ".busy"},  32'(busy),        32'(bsy));
        check({tag, ".zero"},  32'(zero),        32'(cnt == 0));
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        auto_reload = 1'b0;
        repeat (10) tick();
        check_all("reset", 0, 1'b0, 1'b0);
        reset = 1'b0;

`ifdef DOWN_COUNTER_PRESCALE_EN
        // PRESCALE=4: load 2, one decrement every 4 enabled cycles.
        load = 1'b1; load_value = 4'd2; enable = 1'b1; auto_reload = 1'b0;
        tick();
        check_all("p.load", 2, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i < 4)       check_all($sformatf("p.c%0d", i), 2, 1'b0, 1'b1);
            else if (i < 8)  check_all($sformatf("p.c%0d", i), 1, 1'b0, 1'b1);
            else if (i == 8) check_all("p.c8", 0, 1'b1, 1'b0);
            else             check_all("p.c9", 0, 1'b0, 1'b0);
        end
        // Prescaler holds while enable is low.
        load = 1'b1; load_value = 4'd1; enable = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick();
        enable = 1'b0;
        repeat (5) tick();
        check_all("p.hold", 1, 1'b0, 1'b1);
        enable = 1'b1;
        tick();
        check_all("p.hold1", 1, 1'b0, 1'b1);
        tick();
        check_all("p.tc", 0, 1'b1, 1'b0);
`else
        // 1: one-shot from 3.
        load = 1'b1; load_value = 4'd3; enable = 1'b1; auto_reload = 1'b0;
        tick();
        check_all("t1.load", 3, 1'b0, 1'b1);
        load = 1'b0;
        tick(); check_all("t1.c2", 2, 1'b0, 1'b1);
        tick(); check_all("t1.c1", 1, 1'b0, 1'b1);
        tick(); check_all("t1.c0", 0, 1'b1, 1'b0);
        tick(); check_all("t1.done", 0, 1'b0, 1'b0);
        auto_reload = 1'b1;
        tick(); check_all("t1.hold", 0, 1'b0, 1'b0);

        // 2: auto-reload period 2.
        load = 1'b1; load_value = 4'd2;
        tick();
        check_all("t2.load", 2, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i % 2 == 1) check_all($sformatf("t2.c%0d", i), 1, 1'b0, 1'b1);
            else            check_all($sformatf("t2.c%0d", i), 2, 1'b1, 1'b1);
        end

        // 3: hold while enable is low.
        load = 1'b1; load_value = 4'd5; auto_reload = 1'b0;
        tick();
        check_all("t3.load", 5, 1'b0, 1'b1);
        load = 1'b0;
        tick(); check_all("t3.c4", 4, 1'b0, 1'b1);
        tick(); check_all("t3.c3", 3, 1'b0, 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("t3.hold%0d", i), 3, 1'b0, 1'b1);
        end
        enable = 1'b1;
        tick(); check_all("t3.c2", 2, 1'b0, 1'b1);

        // 4: load coincident with terminal event wins; load of 0 goes IDLE.
        tick(); check_all("t4.c1", 1, 1'b0, 1'b1);
        load = 1'b1; load_value = 4'd9;
        tick(); check_all("t4.load9", 9, 1'b0, 1'b1);
        load_value = 4'd0;
        tick(); check_all("t4.load0", 0, 1'b0, 1'b0);
        load = 1'b0;
        tick(); check_all("t4.idle", 0, 1'b0, 1'b0);

        // auto_reload only matters at the terminal event.
        load = 1'b1; load_value = 4'd3; auto_reload = 1'b0;
        tick();
        load = 1'b0; auto_reload = 1'b1;
        tick(); check_all("ar.c2", 2, 1'b0, 1'b1);
        auto_reload = 1'b0;
        tick(); check_all("ar.c1", 1, 1'b0, 1'b1);
        auto_reload = 1'b1;
        tick(); check_all("ar.reload", 3, 1'b1, 1'b1);

        // 5: asynchronous reset mid-cycle while the pulse is high at count 6.
        load = 1'b1; load_value = 4'd6;
        tick();
        load = 1'b0;
        repeat (6) tick();
        check_all("t5.pre", 6, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all("t5.async", 0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick(); check_all("t5.after", 0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counter and timer, the count-down counterpart of the existing 4-bit up counter.
- Software or a sequencer loads a start value; the block decrements on each enabled clock.
- At terminal count it raises a one-cycle pulse, then either stops or auto-reloads.
- Drives periodic events and timeouts alongside the up counter in the same clk/reset domain.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE, 4, enabled cycles per decrement; only used when DOWN_COUNTER_PRESCALE_EN is defined; legal range 1..256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset; asynchronous, active-high.
- enable  input  1  count enable; decrements only while high in RUN.
- load  input  1  load strobe; samples load_value; priority over enable.
- load_value  input  WIDTH  start/reload value.
- auto_reload  input  1  1 = restart from the reload register at terminal count; 0 = stop.
- counter_out  output  WIDTH  current count (registered).
- zero  output  1  counter_out == 0 (combinational from register).
- busy  output  1  state == RUN.
- tc_pulse  output  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - counter_out=0, reload_reg=0, state=IDLE, tc_pulse=0, zero=1, busy=0.
  - Prescaler count cleared.
- States: IDLE (no value loaded), RUN (counting), DONE (expired, non-reload).
- load=1, any state:
  - Next edge: counter_out<=load_value, reload_reg<=load_value, tc_pulse<=0.
  - State goes to RUN if load_value!=0, else IDLE.
  - enable is ignored that cycle.
- RUN, load=0, enable=1, counter_out>1: counter_out decrements by 1 next edge.
- RUN, load=0, enable=1, counter_out==1 (terminal event):
  - tc_pulse=1 for exactly the following cycle.
  - auto_reload=1: counter_out<=reload_reg, stay RUN. Period = reload_reg cycles; never passes through 0.
  - auto_reload=0: counter_out<=0, state=DONE.
- RUN with enable=0: hold value; no pulse.
- IDLE/DONE: hold counter_out; enable and auto_reload ignored; exit only via load.
- load coincident with terminal event: load wins, tc_pulse stays 0.
- auto_reload is sampled only at the terminal event; changing it mid-count has no other effect.
- No wrap-around: the counter never decrements below 0 (the 0→max transition is impossible).
- Latency:
  - load → counter_out: 1 cycle.
  - Last enabled decrement → tc_pulse: 1 cycle (tc_pulse is high in the cycle counter_out shows 0 or the reload value).

Optional Feature:
Macro DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - A prescaler counts enabled RUN cycles 0..PRESCALE-1.
  - A decrement or terminal event occurs only on the cycle the prescaler wraps to 0.
  - The prescaler is cleared by reset and by load, and holds when enable=0.
  - With PRESCALE=1, behaviour is identical to the macro being undefined.
- Undefined: no prescaler logic; every enabled RUN cycle decrements; PRESCALE is unused.

Decomposition:
- Package down_counter_pkg holds:
  - state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant DEFAULT_WIDTH=4.
- One natural sub-module: down_counter_prescaler (tick generator; ports clk, reset, clear, enable, tick), instantiated only under DOWN_COUNTER_PRESCALE_EN.

Test Plan:
(WIDTH=4, macro undefined unless stated.)
1. Reset high for 10 ticks, then load load_value=4'd3, auto_reload=0, enable=1 → counter_out 3,2,1,0 on successive edges; tc_pulse high only in the cycle counter_out=0; then busy=0, zero=1, counter holds 0.
2. load 4'd2, auto_reload=1, enable=1 for 8 cycles → counter_out 2,1,2,1,2,1…; tc_pulse every 2nd cycle coinciding with counter_out=2; busy stays 1.
3. load 4'd5, enable=1 for 2 cycles, enable=0 for 3 cycles, enable=1 → counter_out 5,4,3,3,3,3,2…; no pulse while held.
4. Counter at 1 with enable=1 and load=1, load_value=4'd9 on the same edge → counter_out=9, tc_pulse=0, state RUN. Separately, load 4'd0 → state IDLE, zero=1, no pulse.
5. Assert reset asynchronously mid-count at counter_out=6 (between edges) → counter_out=0, tc_pulse=0, busy=0 immediately without a clock edge.
6. DOWN_COUNTER_PRESCALE_EN, PRESCALE=4: load 4'd2, enable=1 → counter_out changes every 4 cycles (2→1→0); tc_pulse once, 8 cycles after the load edge.
